// File: rtl/dp_ram_bank_if.sv
// Dual-port RAM bus: two independent read/write ports plus the ready flag.
// The master drives addresses, data and enables; the RAM (slave) returns read data.
interface dp_ram_bank_if #(
  parameter int WIDTH  = 28,
  parameter int ADDR_W = 12,
  parameter int LANE_W = 8
);
  localparam int NL = (WIDTH + LANE_W - 1) / LANE_W;

  logic [ADDR_W-1:0] address_a;
  logic              wren_a;
  logic [NL-1:0]     byteena_a;
  logic [WIDTH-1:0]  data_a;
  logic [WIDTH-1:0]  q_a;

  logic [ADDR_W-1:0] address_b;
  logic              wren_b;
  logic [NL-1:0]     byteena_b;
  logic [WIDTH-1:0]  data_b;
  logic [WIDTH-1:0]  q_b;

  logic              ready;

  modport master (
    output address_a, wren_a, byteena_a, data_a,
    output address_b, wren_b, byteena_b, data_b,
    input  q_a, q_b, ready
  );

  modport slave (
    input  address_a, wren_a, byteena_a, data_a,
    input  address_b, wren_b, byteena_b, data_b,
    output q_a, q_b, ready
  );
endinterface

// File: rtl/dp_ram_bank.sv
// True-dual-port synchronous RAM with lane enables, selectable mixed-port
// read-during-write, optional output register and a post-reset fill sequencer.
module dp_ram_bank #(
  parameter int              WIDTH          = 28,
  parameter int              ADDR_W         = 12,
  parameter int              LANE_W         = 8,
  parameter string           RDW_MIXED      = "OLD",
  parameter int              OUT_REG        = 0,
  parameter int              CLEAR_ON_RESET = 1,
  parameter logic [WIDTH-1:0] INIT_VALUE    = '0
) (
  input  logic           clock0,
  input  logic           aclr0_n,
  dp_ram_bank_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit RDW_NEW = (RDW_MIXED == "NEW");
  localparam logic [ADDR_W-1:0] CNT_ONE = 1;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              ready_r;
  logic              port_en;

  logic [WIDTH-1:0]  mask_a, mask_b;
  logic [WIDTH-1:0]  old_a, old_b;
  logic [WIDTH-1:0]  post_a, post_b;
  logic [WIDTH-1:0]  rd_a, rd_b;
  logic [WIDTH-1:0]  q1_a, q1_b;
  logic              hit_ba, hit_ab;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane_mask
    assign mask_a[g] = bus.byteena_a[g / LANE_W];
    assign mask_b[g] = bus.byteena_b[g / LANE_W];
  end

  assign old_a = mem[bus.address_a];
  assign old_b = mem[bus.address_b];

  // Post-write word at each port's address: B lanes first, A lanes override on collision.
  always_comb begin
    hit_ba = bus.wren_b && (bus.address_b == bus.address_a);
    hit_ab = bus.wren_a && (bus.address_a == bus.address_b);

    post_a = old_a;
    if (hit_ba)     post_a = (post_a & ~mask_b) | (bus.data_b & mask_b);
    if (bus.wren_a) post_a = (post_a & ~mask_a) | (bus.data_a & mask_a);

    post_b = old_b;
    if (bus.wren_b) post_b = (post_b & ~mask_b) | (bus.data_b & mask_b);
    if (hit_ab)     post_b = (post_b & ~mask_a) | (bus.data_a & mask_a);

    rd_a = (RDW_NEW || bus.wren_a) ? post_a : old_a;
    rd_b = (RDW_NEW || bus.wren_b) ? post_b : old_b;
  end

  // Without a fill sequence, ready doubles as the "out of reset" qualifier for writes.
  assign port_en = (state == ST_RUN) && ((CLEAR_ON_RESET != 0) || ready_r);

  always_ff @(posedge clock0 or negedge aclr0_n) begin
    if (!aclr0_n) begin
      state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clr_cnt <= '0;
      ready_r <= 1'b0;
      q1_a    <= '0;
      q1_b    <= '0;
    end else begin
      ready_r <= (state == ST_RUN);
      if (state == ST_CLEAR) begin
        clr_cnt <= clr_cnt + CNT_ONE;
        if (clr_cnt == '1) state <= ST_RUN;
      end
      q1_a <= (state == ST_RUN) ? rd_a : '0;
      q1_b <= (state == ST_RUN) ? rd_b : '0;
    end
  end

  always_ff @(posedge clock0) begin
    if (state == ST_CLEAR) begin
      mem[clr_cnt] <= INIT_VALUE;
    end else if (port_en) begin
      if (bus.wren_b) mem[bus.address_b] <= post_b;
      if (bus.wren_a) mem[bus.address_a] <= post_a;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [WIDTH-1:0] q2_a, q2_b;
    always_ff @(posedge clock0 or negedge aclr0_n) begin
      if (!aclr0_n) begin
        q2_a <= '0;
        q2_b <= '0;
      end else begin
        q2_a <= q1_a;
        q2_b <= q1_b;
      end
    end
    assign bus.q_a = q2_a;
    assign bus.q_b = q2_b;
  end else begin : g_no_out_reg
    assign bus.q_a = q1_a;
    assign bus.q_b = q1_b;
  end

  assign bus.ready = ready_r;
endmodule

// File: tb/tb_dp_ram_bank.sv
// Scoreboard bench for dp_ram_bank: two instances (OLD/no out reg, NEW/out reg)
// share stimulus; a word-level memory model predicts every read.
module tb_dp_ram_bank;
  localparam int W     = 28;
  localparam int AW    = 4;
  localparam int LW    = 8;
  localparam int NL    = 4;
  localparam int DEPTH = 16;
  localparam logic [W-1:0] INIT = 28'h5A5A5A5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dp_ram_bank_if #(.WIDTH(W), .ADDR_W(AW), .LANE_W(LW)) bus_o ();
  dp_ram_bank_if #(.WIDTH(W), .ADDR_W(AW), .LANE_W(LW)) bus_n ();

  dp_ram_bank #(
    .WIDTH(W), .ADDR_W(AW), .LANE_W(LW), .RDW_MIXED("OLD"),
    .OUT_REG(0), .CLEAR_ON_RESET(1), .INIT_VALUE(INIT)
  ) dut_o (.clock0(clk), .aclr0_n(rst_n), .bus(bus_o));

  dp_ram_bank #(
    .WIDTH(W), .ADDR_W(AW), .LANE_W(LW), .RDW_MIXED("NEW"),
    .OUT_REG(1), .CLEAR_ON_RESET(1), .INIT_VALUE(INIT)
  ) dut_n (.clock0(clk), .aclr0_n(rst_n), .bus(bus_n));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int since_rel = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) since_rel <= 0;
    else        since_rel <= since_rel + 1;

  typedef struct {
    int           due;
    logic [W-1:0] exp;
  } exp_t;

  exp_t sb_oa[$];
  exp_t sb_ob[$];
  exp_t sb_na[$];
  exp_t sb_nb[$];

  logic [W-1:0] model [DEPTH];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [W-1:0] apply(input logic [W-1:0] old, input logic [NL-1:0] be,
                                         input logic [W-1:0] data);
    logic [W-1:0] m;
    m = '0;
    for (int l = 0; l < NL; l++)
      if (be[l]) m = m | (W'(8'hFF) << (l * LW));
    return (old & ~m) | (data & m);
  endfunction

  task automatic reset_model();
    for (int i = 0; i < DEPTH; i++) model[i] = INIT;
  endtask

  task automatic flush_sb();
    sb_oa.delete(); sb_ob.delete(); sb_na.delete(); sb_nb.delete();
  endtask

  // One bus cycle on both instances; expectations are queued with their due cycle.
  task automatic do_cycle(input int aa, input bit wa, input logic [NL-1:0] ba, input logic [W-1:0] da,
                          input int ab, input bit wb, input logic [NL-1:0] bb, input logic [W-1:0] db);
    logic [W-1:0] pa, pb, ea_old, eb_old, ea_new, eb_new;
    bit eff;
    bus_o.address_a = AW'(aa); bus_o.wren_a = wa; bus_o.byteena_a = ba; bus_o.data_a = da;
    bus_o.address_b = AW'(ab); bus_o.wren_b = wb; bus_o.byteena_b = bb; bus_o.data_b = db;
    bus_n.address_a = AW'(aa); bus_n.wren_a = wa; bus_n.byteena_a = ba; bus_n.data_a = da;
    bus_n.address_b = AW'(ab); bus_n.wren_b = wb; bus_n.byteena_b = bb; bus_n.data_b = db;

    eff = (since_rel >= DEPTH);
    pa = model[aa];
    if (wb && ab == aa) pa = apply(pa, bb, db);
    if (wa)             pa = apply(pa, ba, da);
    pb = model[ab];
    if (wb)             pb = apply(pb, bb, db);
    if (wa && aa == ab) pb = apply(pb, ba, da);

    ea_old = eff ? (wa ? pa : model[aa]) : '0;
    eb_old = eff ? (wb ? pb : model[ab]) : '0;
    ea_new = eff ? pa : '0;
    eb_new = eff ? pb : '0;
    sb_oa.push_back('{cyc + 1, ea_old});
    sb_ob.push_back('{cyc + 1, eb_old});
    sb_na.push_back('{cyc + 2, ea_new});
    sb_nb.push_back('{cyc + 2, eb_new});

    if (eff) begin
      if (wa) model[aa] = pa;
      if (wb) model[ab] = pb;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cycle(input bit force_wr);
    do_cycle($urandom_range(0, DEPTH - 1), force_wr | $urandom_range(0, 1), NL'($urandom),
             W'($urandom), $urandom_range(0, DEPTH - 1), force_wr | $urandom_range(0, 1),
             NL'($urandom), W'($urandom));
  endtask

  task automatic set_idle();
    bus_o.wren_a = 1'b0; bus_o.wren_b = 1'b0; bus_n.wren_a = 1'b0; bus_n.wren_b = 1'b0;
  endtask

  // Monitor: ready every cycle, read data whenever a queued expectation falls due.
  always @(negedge clk) begin
    exp_t e;
    logic [W-1:0] er;
    er = ((rst_n === 1'b1) && (since_rel >= DEPTH + 1)) ? W'(1) : W'(0);
    check("ready_old", W'(bus_o.ready), er);
    check("ready_new", W'(bus_n.ready), er);
    while (sb_oa.size() != 0 && sb_oa[0].due <= cyc) begin
      e = sb_oa.pop_front(); check("q_a_old", bus_o.q_a, e.exp);
    end
    while (sb_ob.size() != 0 && sb_ob[0].due <= cyc) begin
      e = sb_ob.pop_front(); check("q_b_old", bus_o.q_b, e.exp);
    end
    while (sb_na.size() != 0 && sb_na[0].due <= cyc) begin
      e = sb_na.pop_front(); check("q_a_new", bus_n.q_a, e.exp);
    end
    while (sb_nb.size() != 0 && sb_nb[0].due <= cyc) begin
      e = sb_nb.pop_front(); check("q_b_new", bus_n.q_b, e.exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus_o.address_a = '0; bus_o.byteena_a = '0; bus_o.data_a = '0;
    bus_o.address_b = '0; bus_o.byteena_b = '0; bus_o.data_b = '0;
    bus_n.address_a = '0; bus_n.byteena_a = '0; bus_n.data_a = '0;
    bus_n.address_b = '0; bus_n.byteena_b = '0; bus_n.data_b = '0;
    set_idle();
    reset_model();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_q_a_old", bus_o.q_a, '0);
    check("rst_q_b_old", bus_o.q_b, '0);
    check("rst_q_a_new", bus_n.q_a, '0);
    check("rst_q_b_new", bus_n.q_b, '0);
    rst_n = 1'b1;

    // Partial fill, then a one-cycle reset that must restart it.
    while (since_rel < 10) rand_cycle(1'b1);
    #1;
    rst_n = 1'b0;
    flush_sb();
    #1;
    check("midclr_ready_old", W'(bus_o.ready), '0);
    check("midclr_ready_new", W'(bus_n.ready), '0);
    check("midclr_q_a_old", bus_o.q_a, '0);
    check("midclr_q_b_old", bus_o.q_b, '0);
    check("midclr_q_a_new", bus_n.q_a, '0);
    check("midclr_q_b_new", bus_n.q_b, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    reset_model();

    // Writes during the fill must be dropped.
    while (since_rel < DEPTH) rand_cycle(1'b1);

    for (int i = 0; i < DEPTH; i++) do_cycle(i, 1'b0, '0, '0, DEPTH - 1 - i, 1'b0, '0, '0);

    // Write on A, read on B next cycle.
    do_cycle(3, 1'b1, 4'hF, 28'hABCDEF1, 0, 1'b0, '0, '0);
    do_cycle(0, 1'b0, '0, '0, 3, 1'b0, '0, '0);
    // Partial-lane write with same-port read.
    do_cycle(5, 1'b1, 4'hF, 28'hFFFFFFF, 1, 1'b0, '0, '0);
    do_cycle(5, 1'b1, 4'b0101, 28'h0000000, 1, 1'b0, '0, '0);
    do_cycle(5, 1'b0, '0, '0, 5, 1'b0, '0, '0);
    // No-op write still reads.
    do_cycle(5, 1'b1, 4'b0000, 28'h1234567, 3, 1'b0, '0, '0);
    // Write-write collision.
    do_cycle(7, 1'b1, 4'b0011, 28'h1111111, 7, 1'b1, 4'b1110, 28'h2222222);
    do_cycle(7, 1'b0, '0, '0, 7, 1'b0, '0, '0);
    // Mixed-port read-during-write both directions.
    do_cycle(9, 1'b1, 4'hF, 28'h0000001, 2, 1'b0, '0, '0);
    do_cycle(9, 1'b1, 4'hF, 28'h0000002, 9, 1'b0, '0, '0);
    do_cycle(9, 1'b0, '0, '0, 9, 1'b1, 4'hF, 28'h0000003);
    do_cycle(9, 1'b0, '0, '0, 9, 1'b0, '0, '0);

    repeat (600) rand_cycle(1'b0);

    set_idle();
    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drain", W'(sb_oa.size() + sb_ob.size() + sb_na.size() + sb_nb.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
